// File: rtl/div_u.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring divider, one quotient bit per cycle, with fast paths for /0 and overflow.
module div_u (
    input  logic        clk,
    input  logic        reset,
    input  logic        Enable,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [11:0] funct3,
    output logic [31:0] rd,
    output logic        Busy,
    output logic        Done
);

    localparam logic [11:0] OpDiv  = 12'b011000110011;
    localparam logic [11:0] OpDivu = 12'b011010110011;
    localparam logic [11:0] OpRem  = 12'b011100110011;
    localparam logic [11:0] OpRemu = 12'b011110110011;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [4:0]  r_cnt;
    logic [31:0] r_rd;

    logic        w_valid;
    logic        w_signed;
    logic        w_accept;
    logic        w_dbz;
    logic        w_ovf;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_res_q;
    logic [31:0] w_res_r;

    assign w_valid  = (funct3 == OpDiv) || (funct3 == OpDivu) ||
                      (funct3 == OpRem) || (funct3 == OpRemu);
    // funct3[0] of the instruction (bit 7 here) distinguishes unsigned from signed.
    assign w_signed = ~funct3[7];
    assign w_accept = ((r_state == StIdle) || (r_state == StDone)) && Enable && w_valid;
    assign w_dbz    = (rs2 == 32'd0);
    assign w_ovf    = w_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign w_abs_a  = (w_signed && rs1[31]) ? -rs1 : rs1;
    assign w_abs_b  = (w_signed && rs2[31]) ? -rs2 : rs2;

    assign w_shift  = {r_rem[31:0], r_quo[31]};
    assign w_trial  = w_shift - {1'b0, r_div};
    assign w_res_q  = r_neg_q ? -r_quo : r_quo;
    assign w_res_r  = r_neg_r ? -r_rem[31:0] : r_rem[31:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) w_state_nxt = (w_dbz || w_ovf) ? StFix : StCalc;
            end
            StCalc: begin
                if (r_cnt == 5'd31) w_state_nxt = StFix;
            end
            StFix: begin
                w_state_nxt = StDone;
            end
            StDone: begin
                if (w_accept) w_state_nxt = (w_dbz || w_ovf) ? StFix : StCalc;
                else          w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= 33'd0;
            r_quo    <= 32'd0;
            r_div    <= 32'd0;
            r_cnt    <= 5'd0;
            r_rd     <= 32'd0;
        end else if (w_accept) begin
            r_is_rem <= funct3[8];
            r_cnt    <= 5'd0;
            r_div    <= w_abs_b;
            if (w_dbz) begin
                r_quo   <= 32'hFFFF_FFFF;
                r_rem   <= {1'b0, rs1};
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else if (w_ovf) begin
                r_quo   <= 32'h8000_0000;
                r_rem   <= 33'd0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_quo   <= w_abs_a;
                r_rem   <= 33'd0;
                r_neg_q <= w_signed & (rs1[31] ^ rs2[31]);
                r_neg_r <= w_signed & rs1[31];
            end
        end else if (r_state == StCalc) begin
            r_cnt <= r_cnt + 5'd1;
            r_quo <= {r_quo[30:0], ~w_trial[32]};
            r_rem <= w_trial[32] ? w_shift : w_trial;
        end else if (r_state == StFix) begin
            r_rd <= r_is_rem ? w_res_r : w_res_q;
        end
    end

    assign rd   = r_rd;
    assign Busy = (r_state == StCalc) || (r_state == StFix);
    assign Done = (r_state == StDone);

endmodule

// File: tb/tb_div_u.sv
// Self-checking bench for div_u: directed corner cases plus random operations
// compared against a 64-bit arithmetic reference model.
module tb_div_u;

    localparam logic [11:0] OpDiv  = 12'b011000110011;
    localparam logic [11:0] OpDivu = 12'b011010110011;
    localparam logic [11:0] OpRem  = 12'b011100110011;
    localparam logic [11:0] OpRemu = 12'b011110110011;

    logic        clk = 1'b0;
    logic        reset;
    logic        Enable;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [11:0] funct3;
    logic [31:0] rd;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;
    logic [11:0] ops [4] = '{OpDiv, OpDivu, OpRem, OpRemu};

    div_u dut (
        .clk    (clk),
        .reset  (reset),
        .Enable (Enable),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .rd     (rd),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [11:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic   is_rem;
        logic   is_sgn;
        longint sa;
        longint sb;
        longint q;
        longint r;
        is_rem = (op == OpRem) || (op == OpRemu);
        is_sgn = (op == OpDiv) || (op == OpRem);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return is_rem ? 32'(r) : 32'(q);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one operation (from IDLE or DONE) and follow it to Done.
    task automatic run_op(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input string tag);
        logic [31:0] exp;
        logic [31:0] prev;
        bit          special;
        int          n;
        int          busy_low;
        int          rd_moves;
        exp     = ref_model(op, a, b);
        special = (b == 32'd0) ||
                  (((op == OpDiv) || (op == OpRem)) && (a == 32'h8000_0000) &&
                   (b == 32'hFFFF_FFFF));
        prev    = rd;
        Enable  = 1'b1;
        funct3  = op;
        rs1     = a;
        rs2     = b;
        @(posedge clk);
        #1;
        Enable   = 1'b0;
        n        = 0;
        busy_low = 0;
        rd_moves = 0;
        while (Done !== 1'b1 && n < 100) begin
            if (Busy !== 1'b1) busy_low++;
            if (rd !== prev) rd_moves++;
            if (disturb) begin
                Enable = 1'($urandom_range(0, 1));
                funct3 = ops[$urandom_range(0, 3)];
                rs1    = $urandom;
                rs2    = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
        end
        Enable = 1'b0;
        check({tag, " rd"}, rd, exp);
        check({tag, " latency"}, 32'(n), special ? 32'd1 : 32'd33);
        check({tag, " busy gaps"}, 32'(busy_low), 32'd0);
        check({tag, " early rd change"}, 32'(rd_moves), 32'd0);
        check({tag, " busy at done"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] held;
        int          hits;

        reset  = 1'b1;
        Enable = 1'b0;
        rs1    = 32'd0;
        rs2    = 32'd0;
        funct3 = 12'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset rd", rd, 32'd0);
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset done", {31'd0, Done}, 32'd0);

        run_op(OpDivu, 32'd100, 32'd7, 1'b0, "divu 100/7");
        check("divu 100/7 const", rd, 32'd14);
        run_op(OpRem, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem -7/2");
        check("rem -7/2 const", rd, 32'hFFFF_FFFF);
        run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
        check("div -7/2 const", rd, 32'hFFFF_FFFD);

        run_op(OpDiv, 32'h1234_5678, 32'd0, 1'b0, "div by0");
        run_op(OpDivu, 32'h1234_5678, 32'd0, 1'b0, "divu by0");
        run_op(OpRem, 32'h1234_5678, 32'd0, 1'b0, "rem by0");
        check("rem by0 const", rd, 32'h1234_5678);
        run_op(OpRemu, 32'h1234_5678, 32'd0, 1'b0, "remu by0");

        run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf");
        check("div ovf const", rd, 32'h8000_0000);
        run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem ovf");

        run_op(OpDiv, 32'hDEAD_BEEF, 32'd1234, 1'b1, "div disturbed");
        run_op(OpRemu, 32'hCAFE_F00D, 32'd77, 1'b1, "remu disturbed");

        // Let DONE fall back to IDLE, then an invalid code must be ignored.
        @(posedge clk);
        #1;
        held   = rd;
        hits   = 0;
        Enable = 1'b1;
        funct3 = 12'b000000110011;
        rs1    = 32'd50;
        rs2    = 32'd5;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (Busy !== 1'b0 || Done !== 1'b0) hits++;
        end
        Enable = 1'b0;
        check("invalid op activity", 32'(hits), 32'd0);
        check("invalid op rd", rd, held);

        // Reset in the middle of CALC.
        Enable = 1'b1;
        funct3 = OpDivu;
        rs1    = 32'd1000;
        rs2    = 32'd7;
        @(posedge clk);
        #1;
        Enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid-calc busy", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid reset busy", {31'd0, Busy}, 32'd0);
        check("mid reset done", {31'd0, Done}, 32'd0);
        check("mid reset rd", rd, 32'd0);
        run_op(OpDivu, 32'd9, 32'd3, 1'b0, "divu 9/3");
        check("divu 9/3 const", rd, 32'd3);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = -32'($urandom_range(1, 15));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_op(ops[$urandom_range(0, 3)], a, b, 1'($urandom_range(0, 1)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_u.md
# div_u

Iterative RV32M divide/remainder unit: the inverse companion to the Karatsuba multiplier in the MULT execution path. It accepts DIV, DIVU, REM and REMU operations using the same 12-bit operation code and Enable/Busy handshake as the multiplier. It computes a 32-bit result with a radix-2 restoring algorithm, one quotient bit per cycle. It sits beside the multiplier in the ALU/execute stage and shares its operand and rd write-back paths.

## Interface
- No parameters. Width is fixed at XLEN=32.
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- Enable  input  1  start request; sampled only in IDLE or DONE.
- rs1  input  32  dividend; sampled on the accept edge only.
- rs2  input  32  divisor; sampled on the accept edge only.
- funct3  input  12  operation code {0,1,funct3[2:0],0110011}:
  - DIV = 12'b011000110011
  - DIVU = 12'b011010110011
  - REM = 12'b011100110011
  - REMU = 12'b011110110011
  - any other value: no operation.
- rd  output  32  result register; holds the last result until the next accept edge. Reset value 0.
- Busy  output  1  high in CALC and FIX states. Reset value 0.
- Done  output  1  one-cycle pulse in DONE state; rd is valid while Done=1. Reset value 0.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset value is IDLE.
- Accept condition: state is IDLE or DONE, Enable=1, and funct3 is one of the four valid codes. Any other combination leaves the state unchanged (DONE still moves to IDLE).
- On the accept edge:
  - Latch the operation code.
  - For DIV/REM: store |rs1| and |rs2|. Set neg_q = rs1[31]^rs2[31] and neg_r = rs1[31].
  - For DIVU/REMU: store the raw operands and clear both sign flags.
  - Clear the 33-bit partial remainder and the 5-bit counter.
- Special cases, detected on the accept edge; each skips CALC and goes straight to FIX with the result preloaded:
  - Divide by zero (rs2==0): quotient = 32'hFFFFFFFF, remainder = rs1. Sign fix-up is suppressed.
  - Signed overflow (DIV/REM with rs1==32'h80000000 and rs2==32'hFFFFFFFF): quotient = 32'h80000000, remainder = 0. Sign fix-up is suppressed.
- CALC, one iteration per cycle:
  - Shift {R, Q} left by 1, moving the dividend MSB into R.
  - Compute T = R - D (33-bit). If T is non-negative, R = T and the new Q LSB is 1; otherwise the new Q LSB is 0.
  - The counter increments each cycle. After count 31, go to FIX.
- FIX:
  - rd = neg_q ? -Q : Q for DIV/DIVU.
  - rd = neg_r ? -R[31:0] : R[31:0] for REM/REMU.
  - Then go to DONE.
- DONE: Done=1 for one cycle, then IDLE. A back-to-back accept in DONE goes directly to CALC or FIX.
- Enable is ignored while Busy=1. Operand changes during Busy have no effect.
- Reset in any state, mid-operation included: the next state is IDLE, rd=0, Busy=0, Done=0, and the operation is discarded.

## Timing
- Normal path, accept at edge k:
  - Busy=1 after edge k.
  - CALC occupies edges k+1..k+32.
  - FIX writes rd at edge k+33. Busy=0 and Done=1 after edge k+33.
  - Latency is 33 cycles from accept to Done.
- Special-case path: FIX at edge k+1 writes rd; Done=1 after edge k+1. Latency is 1 cycle of Busy, with Done one cycle after accept.
- rd changes only on a FIX edge or on reset.
- Minimum issue interval is 34 cycles for the normal path and 2 cycles for special cases, since accept is legal in DONE.

## Test plan
- DIVU rs1=100, rs2=7 -> rd=14. Done rises exactly 33 edges after accept; Busy=1 throughout CALC.
- REM rs1=32'hFFFFFFF9 (-7), rs2=2 -> rd=32'hFFFFFFFF (-1). DIV with the same operands -> rd=32'hFFFFFFFD (-3).
- DIV/DIVU/REM/REMU with rs2=0, rs1=32'h12345678:
  - DIV and DIVU -> rd=32'hFFFFFFFF.
  - REM and REMU -> rd=32'h12345678.
  - Done one edge after accept in each case.
- DIV rs1=32'h80000000, rs2=32'hFFFFFFFF -> rd=32'h80000000. REM with the same operands -> rd=0. Fast-path timing.
- Pulse reset at CALC cycle 10 -> after that edge Busy=0, Done=0, rd=0. A new DIVU 9/3 then completes normally with rd=3.
- During Busy, toggle Enable and change rs1/rs2/funct3 -> the in-flight result is unaffected. An invalid funct3 with Enable=1 in IDLE keeps Busy=0 and never pulses Done.
